divu_arbiter: RTL
=================

// Module: divu_arbiter
// PURPOSE
//  Shares one unsigned Q(WIDTH-FBITS).FBITS divu instance between N_REQ requesters:
//  the projector z-reciprocal path, the rasterizer edge-setup path and others.
//  - Fair round-robin grant; at most one division in flight.
//  - Per-requester valid/ready request and response channels; result goes only to the owner.
//  - Divide-by-zero is resolved locally, without starting the divider.
// PARAMETERS
//  N_REQ  3   number of requesters (2..8)
//  WIDTH  32  operand/result width, passed to divu
//  FBITS  16  fractional bits, passed to divu
// PORTS
//  clk         in   1                clock
//  rst         in   1                reset, asynchronous, active-high
//  req_valid   in   N_REQ            request i presents operands
//  req_ready   out  N_REQ            request i accepted this cycle (one-hot or zero)
//  req_a       in   N_REQ x WIDTH    dividend per requester
//  req_b       in   N_REQ x WIDTH    divisor per requester
//  resp_valid  out  N_REQ            result valid for requester i (one-hot or zero)
//  resp_ready  in   N_REQ            requester i consumes result
//  resp_val    out  WIDTH            quotient, shared bus, meaningful only with resp_valid
//  resp_dbz    out  1                divide-by-zero flag, qualified by resp_valid
//  resp_ovf    out  1                overflow flag from divu, qualified by resp_valid
//  busy        out  1                state != IDLE
// BEHAVIOUR
//  - Reset values:
//    - req_ready=0, resp_valid=0, resp_val=0, resp_dbz=0, resp_ovf=0, busy=0.
//    - state=IDLE, rr_ptr=0; the divu instance is reset by the same rst.
//  - FSM states: IDLE, START, WAIT, RESP.
//  - IDLE:
//    - grant = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
//    - req_ready[grant]=1, combinational, only in IDLE. Transfer happens on valid&&ready.
//    - On transfer, latch a, b and owner=grant.
//    - If b==0: next state RESP with val=0, dbz=1, ovf=0. Otherwise next state START.
//  - START: start=1 to divu for exactly one cycle -> WAIT.
//  - WAIT: hold until divu done. Then register val, dbz=0, ovf from divu -> RESP.
//  - RESP:
//    - resp_valid[owner]=1; val, dbz and ovf held stable until resp_ready[owner].
//    - On handshake: rr_ptr <= (owner+1) mod N_REQ, then go to IDLE.
//    - resp_ready of non-owners is ignored.
//  - Latency:
//    - Normal path: accept at cycle 0, start at 1, resp_valid in the cycle after divu done.
//    - b==0 path: resp_valid at cycle 1.
//  - Next grant is not taken in the same cycle as the response handshake: a new transfer
//    earliest 1 cycle after the handshake (IDLE cycle).
//  - No request is accepted while busy. req_a and req_b are sampled only at transfer.
//  - A requester may drop req_valid before it is granted; nothing is latched for it.
//  - rr_ptr only advances on completed responses, so there is no starvation.
//    A requester held valid is served within N_REQ transactions.
//  - Reset mid-operation:
//    - Any in-flight division or pending response is discarded; no resp_valid after reset.
//    - rr_ptr returns to 0.
//  - Widths: operands unsigned WIDTH bits, no sign handling here. Callers pass |z|.
// STRUCTURE
//  - math_pkg: add typedef div_req_t {a,b} and div_resp_t {val,dbz,ovf}, sized by WIDTH,
//    plus localparam DIV_ONE_Q16 = 32'h0001_0000.
//  - Sub-module: the existing divu, instantiated once. Arbitration is a local function.
//  - Optional sub-module rr_arbiter (N_REQ one-hot grant from req mask + rr_ptr).
// TESTING
//  1. Single req0, a=0x0001_0000, b=0x0002_0000.
//     -> resp_valid[0], val=0x0000_8000, dbz=0, ovf=0; busy low again one cycle after
//        the handshake.
//  2. req0, req1, req2 all valid with b=0x0001_0000, 0x0004_0000, 0x0000_4000.
//     -> served in order 0,1,2; val=0x0001_0000, 0x0000_4000, 0x0004_0000;
//        never two resp_valid bits set.
//  3. b=0 on req1.
//     -> resp_valid[1] at cycle 1 after accept, val=0, dbz=1; divu start never pulses.
//  4. Response backpressure: hold resp_ready[0]=0 for 10 cycles.
//     -> resp_valid and val stable; req_ready stays 0 for all requesters.
//  5. req1 continuously valid while req0 re-requests every time.
//     -> grants alternate 0,1,0,1 (no starvation).
//  6. Assert rst during WAIT.
//     -> all outputs 0 next cycle; a fresh request afterwards returns a correct result.

Source files
------------

// File: rtl/math_pkg.sv
// -----------------------------------------------------------------------------
// math_pkg
//  Shared types and constants for the fixed-point divide path.
//  - div_req_t / div_resp_t : operand pair and result bundle at the default
//    32-bit datapath width.
//  - DIV_ONE_Q16            : 1.0 in Q16.16.
//  - arb_state_e            : state encoding of the divider arbiter.
// -----------------------------------------------------------------------------
package math_pkg;

   localparam int DIV_W = 32;
   localparam logic [31:0] DIV_ONE_Q16 = 32'h0001_0000;

   typedef struct packed {
      logic [DIV_W-1:0] a;
      logic [DIV_W-1:0] b;
   } div_req_t;

   typedef struct packed {
      logic [DIV_W-1:0] val;
      logic             dbz;
      logic             ovf;
   } div_resp_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT,
      ST_RESP
   } arb_state_e;

endpackage

// File: rtl/divu.sv
// -----------------------------------------------------------------------------
// divu
//  Iterative unsigned fixed-point divider: q = (a << FBITS) / b.
//  One quotient bit per cycle (WIDTH+FBITS cycles), restoring algorithm.
//  If the quotient does not fit in WIDTH bits, ovf_o is set and q_o saturates
//  to all ones. b == 0 is not handled here; callers must filter it.
// Ports
//  clk, rst  clock, asynchronous active-high reset
//  start_i   1-cycle pulse, samples a_i / b_i
//  a_i, b_i  dividend / divisor, WIDTH bits
//  done_o    1-cycle pulse, q_o / ovf_o valid while done_o is high (and held after)
//  q_o       quotient, WIDTH bits
//  ovf_o     quotient overflowed WIDTH bits
// -----------------------------------------------------------------------------
module divu #(
   parameter int WIDTH = 32,
   parameter int FBITS = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] q_o,
   output logic             ovf_o
);

   localparam int QW = WIDTH + FBITS;
   localparam int CW = $clog2(QW + 1);

   logic             busy_q;
   logic             done_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] b_q;
   // Dividend bits shift out of the top while quotient bits shift in below.
   logic [QW-1:0]    dq_q;

   logic [WIDTH:0]   shift_d;
   logic [WIDTH:0]   diff_d;
   logic             fits_d;

   always_comb begin
      shift_d = {rem_q, dq_q[QW-1]};
      diff_d  = shift_d - {1'b0, b_q};
      fits_d  = (shift_d >= {1'b0, b_q});
   end

   // NOTE: clocked state uses non-blocking assignments so every register sees
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         cnt_q  <= '0;
         rem_q  <= '0;
         b_q    <= '0;
         dq_q   <= '0;
      end else begin
         done_q <= 1'b0;
         if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            rem_q  <= '0;
            b_q    <= b_i;
            dq_q   <= {a_i, {FBITS{1'b0}}};
         end else if (busy_q) begin
            rem_q <= fits_d ? diff_d[WIDTH-1:0] : shift_d[WIDTH-1:0];
            dq_q  <= {dq_q[QW-2:0], fits_d};
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(QW - 1)) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign ovf_o  = |dq_q[QW-1:WIDTH];
   assign q_o    = ovf_o ? {WIDTH{1'b1}} : dq_q[WIDTH-1:0];
   assign done_o = done_q;

endmodule

// File: rtl/divu_arbiter.sv
// -----------------------------------------------------------------------------
// divu_arbiter
//  Shares one divu between N_REQ requesters with round-robin fairness and at
//  most one division in flight. Divide-by-zero is answered locally without
//  starting the divider.
// Ports
//  clk, rst    clock, asynchronous active-high reset
//  req_valid   per-requester operand valid
//  req_ready   per-requester accept (one-hot or zero, only while idle)
//  req_a/req_b per-requester dividend / divisor
//  resp_valid  result valid for the owner (one-hot or zero)
//  resp_ready  per-requester result consume; only the owner's bit matters
//  resp_val    shared quotient bus
//  resp_dbz    divide-by-zero flag
//  resp_ovf    overflow flag from divu
//  busy        arbiter not idle
// -----------------------------------------------------------------------------
module divu_arbiter
   import math_pkg::*;
#(
   parameter int N_REQ = 3,
   parameter int WIDTH = 32,
   parameter int FBITS = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req_valid,
   output logic [N_REQ-1:0]            req_ready,
   input  logic [N_REQ-1:0][WIDTH-1:0] req_a,
   input  logic [N_REQ-1:0][WIDTH-1:0] req_b,
   output logic [N_REQ-1:0]            resp_valid,
   input  logic [N_REQ-1:0]            resp_ready,
   output logic [WIDTH-1:0]            resp_val,
   output logic                        resp_dbz,
   output logic                        resp_ovf,
   output logic                        busy
);

   localparam int IW = $clog2(N_REQ);

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } op_t;

   typedef struct packed {
      logic [WIDTH-1:0] val;
      logic             dbz;
      logic             ovf;
   } res_t;

   // First valid requester scanning from ptr upward, modulo n.
   // Result bit 3 = found, bits 2:0 = index.
   function automatic logic [3:0] rr_pick(input logic [7:0] mask,
                                          input logic [2:0] ptr,
                                          input int         n);
      logic [3:0] res;
      int         idx;
      res = '0;
      // Walk the scan order backwards so the earliest hit is written last.
      for (int k = 7; k >= 0; k--) begin
         if (k < n) begin
            idx = (int'(ptr) + k) % n;
            if (mask[idx[2:0]]) res = {1'b1, idx[2:0]};
         end
      end
      return res;
   endfunction

   arb_state_e     state_q;
   logic [IW-1:0]  rr_ptr_q;
   logic [IW-1:0]  owner_q;
   op_t            op_q;
   res_t           res_q;
   logic           start_q;

   logic [3:0]     pick_d;
   logic           grant_vld_d;
   logic [IW-1:0]  grant_d;
   logic           div_done;
   logic [WIDTH-1:0] div_q;
   logic           div_ovf;

   // NOTE: every combinational output gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      pick_d      = rr_pick(8'(req_valid), 3'(rr_ptr_q), N_REQ);
      grant_vld_d = (state_q == ST_IDLE) && pick_d[3];
      grant_d     = pick_d[IW-1:0];
      req_ready   = '0;
      resp_valid  = '0;
      if (grant_vld_d) req_ready[grant_d] = 1'b1;
      if (state_q == ST_RESP) resp_valid[owner_q] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         op_q     <= '0;
         res_q    <= '0;
         start_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (grant_vld_d) begin
                  owner_q <= grant_d;
                  op_q    <= '{a: req_a[grant_d], b: req_b[grant_d]};
                  if (req_b[grant_d] == '0) begin
                     res_q   <= '{val: '0, dbz: 1'b1, ovf: 1'b0};
                     state_q <= ST_RESP;
                  end else begin
                     start_q <= 1'b1;
                     state_q <= ST_START;
                  end
               end
            end
            ST_START: begin
               start_q <= 1'b0;
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (div_done) begin
                  res_q   <= '{val: div_q, dbz: 1'b0, ovf: div_ovf};
                  state_q <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (resp_ready[owner_q]) begin
                  rr_ptr_q <= (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                  state_q  <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   divu #(
      .WIDTH (WIDTH),
      .FBITS (FBITS)
   ) u_divu (
      .clk     (clk),
      .rst     (rst),
      .start_i (start_q),
      .a_i     (op_q.a),
      .b_i     (op_q.b),
      .done_o  (div_done),
      .q_o     (div_q),
      .ovf_o   (div_ovf)
   );

   assign resp_val = res_q.val;
   assign resp_dbz = res_q.dbz;
   assign resp_ovf = res_q.ovf;
   assign busy     = (state_q != ST_IDLE);

endmodule
